// File: rtl/bcd_scan_ctrl_if.sv
// rtl/bcd_scan_ctrl_if.sv - value source / digit driver signals of the display scan controller
interface bcd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    lz_en;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;
  logic                    err;

  modport master (
    output load, value_in, lz_en,
    input  bcd_out, digit_en, frame_done, err
  );

  modport slave (
    input  load, value_in, lz_en,
    output bcd_out, digit_en, frame_done, err
  );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - multiplexed 7-segment scan controller with double-buffered BCD value
module bcd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  bcd_scan_ctrl_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] pend;
  logic                    pend_v;
  logic [3:0]              bcd_r;
  logic [NUM_DIGITS-1:0]   en_r;
  logic                    fd_r;
  logic                    err_r;

  logic [3:0]            nib;
  logic                  upper_nz;
  logic                  lead_zero;
  logic                  suppress;
  logic [NUM_DIGITS-1:0] en_n;
  logic                  slot_end;
  logic                  boundary;

  always_comb begin
    nib       = 4'd0;
    upper_nz  = 1'b0;
    lead_zero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) nib = disp[4*i +: 4];
    end
    // Walk down from the top digit; digit 0 is excluded so a zero value still shows "0"
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_nz = upper_nz | (disp[4*i +: 4] != 4'd0);
      if (idx == IW'(i)) lead_zero = ~upper_nz;
    end
    suppress = (nib > 4'd9) | (bus.lz_en & lead_zero);
    en_n = '1;
    if ((cnt >= CW'(BLANK_CYCLES)) && !suppress) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IW'(i)) en_n[i] = 1'b0;
      end
    end
  end

  assign slot_end = (cnt == CW'(REFRESH_DIV - 1));
  assign boundary = slot_end && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      disp   <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      bcd_r  <= 4'd0;
      en_r   <= '1;
      fd_r   <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (boundary && pend_v) disp <= pend;
      // A load on the boundary cycle lands in pending; display already took the older value
      if (bus.load) begin
        pend   <= bus.value_in;
        pend_v <= 1'b1;
      end else if (boundary) begin
        pend_v <= 1'b0;
      end
      bcd_r <= suppress ? 4'd0 : nib;
      en_r  <= en_n;
      fd_r  <= boundary;
      if ((cnt == CW'(BLANK_CYCLES)) && (nib > 4'd9)) err_r <= 1'b1;
    end
  end

  assign bus.bcd_out    = bcd_r;
  assign bus.digit_en   = en_r;
  assign bus.frame_done = fd_r;
  assign bus.err        = err_r;
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb/tb_bcd_scan_ctrl.sv - self-checking bench for bcd_scan_ctrl against a frame-level model
module tb_bcd_scan_ctrl;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  bcd_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          k;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pv;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    k      = 0;
    m_disp = 16'h0;
    m_pend = 16'h0;
    m_pv   = 1'b0;
    m_err  = 1'b0;
  endtask

  // One clock: slot position comes from elapsed cycles, digit value from shifting the frame value
  task automatic step(input bit ld, input logic [15:0] val);
    int         cnt;
    int         idx;
    logic [3:0] nib;
    bit         supp;
    bit         bnd;
    logic [3:0] e_en;
    logic [3:0] e_bcd;
    bus.load     = ld;
    bus.value_in = val;
    cnt  = k % RD;
    idx  = (k / RD) % ND;
    nib  = 4'((m_disp >> (4 * idx)) & 16'hF);
    supp = (nib > 9) || (bus.lz_en && idx != 0 && (m_disp >> (4 * idx)) == 16'h0);
    e_bcd = supp ? 4'd0 : nib;
    e_en  = (cnt < BC || supp) ? 4'hF : ~(4'b0001 << idx);
    bnd   = (cnt == RD - 1) && (idx == ND - 1);
    if (cnt == BC && nib > 9) m_err = 1'b1;
    @(posedge clk);
    #1;
    chk("bcd_out", 32'(bus.bcd_out), 32'(e_bcd));
    chk("digit_en", 32'(bus.digit_en), 32'(e_en));
    chk("frame_done", 32'(bus.frame_done), 32'(bnd));
    chk("err", 32'(bus.err), 32'(m_err));
    if (bnd && m_pv) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
    end
    if (ld) begin
      m_pend = val;
      m_pv   = 1'b1;
    end
    k++;
    bus.load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    v = 16'h0;
    for (int i = 0; i < ND; i++) begin
      if ($urandom_range(0, 2) != 0) v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    bus.load     = 1'b0;
    bus.value_in = 16'h0;
    bus.lz_en    = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_bcd", 32'(bus.bcd_out), 32'h0);
    chk("rst_en", 32'(bus.digit_en), 32'hF);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    rst = 1'b0;

    // free run, then a mid-frame load
    run(40);
    step(1'b1, 16'h1234);
    run(70);

    // leading-zero blanking
    bus.lz_en = 1'b1;
    step(1'b1, 16'h0050);
    run(70);
    step(1'b1, 16'h0000);
    run(70);
    bus.lz_en = 1'b0;
    run(40);

    // random valid-BCD loads with random blanking
    repeat (200) begin
      bus.lz_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) step(1'b1, rand_bcd());
      else run(1);
    end
    bus.lz_en = 1'b0;

    // invalid nibble sets sticky err
    step(1'b1, 16'h12A4);
    run(70);
    step(1'b1, 16'h1234);
    run(70);

    // loads just before and on a frame boundary
    for (int g = 0; g < 200 && !((k % RD) == RD - 3 && ((k / RD) % ND) == ND - 1); g++) run(1);
    chk("align", 32'(((k % RD) == RD - 3) && (((k / RD) % ND) == ND - 1)), 32'h1);
    step(1'b1, 16'h5678);
    step(1'b0, 16'h0);
    step(1'b1, 16'h9012);
    run(70);

    // asynchronous reset mid-slot with a load pending
    step(1'b1, 16'h4321);
    run(3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_bcd", 32'(bus.bcd_out), 32'h0);
    chk("arst_en", 32'(bus.digit_en), 32'hF);
    chk("arst_fd", 32'(bus.frame_done), 32'h0);
    chk("arst_err", 32'(bus.err), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run(70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- One shared BCD-to-7-segment decoder serves all digits: this block presents one digit's BCD nibble at a time and drives the per-digit enables.
- Provides double-buffered value loading (tear-free frame update), optional leading-zero blanking, inter-digit dead time against ghosting, and invalid-digit detection.
- Sits between the numeric source (counter/ALU result) and the decoder.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal 2..8.
- REFRESH_DIV, 1000, clock cycles per digit slot; must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 2, dead-time cycles at the start of each slot with all digits off.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures value_in.
- value_in  in  4*NUM_DIGITS  packed BCD; nibble i = digit i; digit 0 is least significant.
- lz_en  in  1  leading-zero blanking enable; sampled each cycle.
- bcd_out  out  4  BCD nibble to the shared decoder, [3] = MSB.
- digit_en  out  NUM_DIGITS  per-digit enable, active-low (1 = off).
- frame_done  out  1  one-cycle pulse after each display-register update opportunity.
- err  out  1  sticky: a nibble greater than 9 was scheduled for display.

Behaviour:
- Reset (asynchronous, immediate):
  - slot counter = 0, digit index = 0
  - display register = 0, pending register = 0, pending flag = 0
  - bcd_out = 0, digit_en = all 1s, frame_done = 0, err = 0
  - Reset mid-operation discards any pending load.
- Slot counter:
  - Counts 0..REFRESH_DIV-1 and then wraps to 0.
  - On wrap, the digit index advances; index NUM_DIGITS-1 wraps to 0.
  - Frame boundary = counter wrap while index = NUM_DIGITS-1.
- Outputs (registered; the value in cycle N reflects the counter, index and display state of cycle N-1):
  - bcd_out = display nibble[index], or 0 when that digit is suppressed.
  - digit_en = all 1s while counter < BLANK_CYCLES.
  - Otherwise bit[index] = 0 unless the digit is suppressed, and all other bits are 1.
- Suppression rules:
  - A digit is suppressed if its nibble is greater than 9.
  - A digit is also suppressed if lz_en=1 and it and every more-significant nibble equal 0.
  - Digit 0 is never suppressed by the leading-zero rule; value 0 displays a single "0".
- err: set when an enabled-phase slot begins (counter = BLANK_CYCLES) for a digit whose nibble is greater than 9. Cleared only by rst.
- Load handshake:
  - load=1 copies value_in into the pending register and sets the pending flag. It is accepted every cycle, with no backpressure.
  - A repeated load before the boundary overwrites the pending register (last load wins).
  - At a frame boundary with pending=1: display register <= pending register and pending is cleared.
- Load coinciding with a frame boundary:
  - The display takes the previously pending value, if any.
  - The new value_in goes to the pending register, and pending stays or becomes 1.
  - The new value is shown after the next frame boundary.
- frame_done: pulses high for exactly 1 cycle in the cycle after every frame boundary, whether or not an update occurred.
- Latency: a load reaches bcd_out no earlier than the first slot following the next frame boundary and no later than one frame (NUM_DIGITS*REFRESH_DIV cycles) plus 1 cycle after it.
- Widths: the index is ceil(log2(NUM_DIGITS)) bits; the counter is ceil(log2(REFRESH_DIV)) bits; there are no arithmetic overflows other than the defined wraps.

Test Plan:
1. Reset, then free-run (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2) -> each slot shows 2 cycles of digit_en=1111 then 6 cycles of 1110, 1101, 1011, 0111 in order, repeating; bcd_out=0; frame_done pulses every 32 cycles.
2. load 16'h1234 mid-frame -> display unchanged until the next frame boundary; after it, bcd_out sequence 4,3,2,1 aligned with digit_en 1110,1101,1011,0111; frame_done high 1 cycle; pending cleared.
3. lz_en=1 with value 16'h0050 -> digit_en never asserts bits 3 and 2; digit 1 shows 5 and digit 0 shows 0; with 16'h0000 only digit 0 enables, showing 0; with lz_en=0 all four digits enable.
4. load 16'h12A4 -> the digit-1 slot keeps digit_en=1111 for the full slot with bcd_out=0; err=1 and stays 1 after a later load of 16'h1234.
5. load A two cycles before the frame boundary, then load B on the boundary cycle -> the next frame shows A; B appears only after the following boundary; pending=1 in between.
6. Assert rst asynchronously mid-slot with a pending load -> digit_en=1111, bcd_out=0 and err=0 immediately without a clock edge; after release the display is 0 and the pending value is never shown.
